uart_rx_fsm: RTL

//  Receive side of the 8N1 UART link: LSB first, 1 start bit, 8 data bits, 1 stop bit, no parity.

---
 rtl/uart_rx_fsm.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: 8N1 UART receiver with 16x oversampling.
// The asynchronous rx line is synchronised before the FSM uses it.
// A free-running tick divider produces the sample ticks.
// Each good byte is delivered with a single-clock rx_valid strobe.
// A bad stop bit produces a single-clock frame_err strobe instead.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle; wait for a 1->0 edge on the synchronised line
// START | count to mid start bit; confirm it is still low (else glitch)
// DATA  | sample 8 data bits at mid bit, LSB first
// STOP  | sample the stop bit at mid bit; strobe byte or framing error
module uart_rx_fsm #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW       = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            rx_meta, rx_s, rx_prev;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [SW-1:0]   s_cnt, s_nxt;
    logic [2:0]      b_cnt, b_nxt;
    logic [7:0]      shift_reg, shift_nxt;
    logic [7:0]      data_nxt;
    logic            valid_nxt, err_nxt;

    // Two-flop synchroniser plus a delayed copy for edge detection; all idle high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Free-running tick divider; counts down and reloads at zero, never restarted by the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick_cnt == '0) begin
            tick_cnt <= TICK_LAST;
        end else begin
            tick_cnt <= tick_cnt - 1'b1;
        end
    end

    assign tick = (tick_cnt == '0);

    // State, counters, shift register and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            s_cnt     <= '0;
            b_cnt     <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            s_cnt     <= s_nxt;
            b_cnt     <= b_nxt;
            shift_reg <= shift_nxt;
            rx_data   <= data_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= err_nxt;
        end
    end

    // Next-state and datapath decisions; START/DATA/STOP move only on a sample tick.
    always_comb begin
        state_nxt = state;
        s_nxt     = s_cnt;
        b_nxt     = b_cnt;
        shift_nxt = shift_reg;
        data_nxt  = rx_data;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                // Only a true 1->0 transition starts a frame, so a held-low break is ignored.
                if (rx_prev && !rx_s) begin
                    state_nxt = START;
                    s_nxt     = '0;
                end
            end

            START: begin
                if (tick) begin
                    if (s_cnt == S_MID) begin
                        s_nxt = '0;
                        if (!rx_s) begin
                            state_nxt = DATA;
                            b_nxt     = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        s_nxt = s_cnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (s_cnt == S_LAST) begin
                        s_nxt     = '0;
                        shift_nxt = {rx_s, shift_reg[7:1]};
                        if (b_cnt == 3'd7) begin
                            state_nxt = STOP;
                        end else begin
                            b_nxt = b_cnt + 1'b1;
                        end
                    end else begin
                        s_nxt = s_cnt + 1'b1;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (s_cnt == S_LAST) begin
                        // Returning to IDLE at mid stop bit leaves half a bit to catch the next start edge.
                        s_nxt     = '0;
                        state_nxt = IDLE;
                        if (rx_s) begin
                            data_nxt  = shift_reg;
                            valid_nxt = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else begin
                        s_nxt = s_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule
